instr_sequencer: RTL and testbench

// Upstream feeder for Processor. Buffers a short program of 13-bit instructions pushed by a host,

---
 rtl/instr_seq_pkg.sv | 24 ++
 rtl/instr_fifo.sv | 63 ++++++
 rtl/instr_sequencer.sv | 129 ++++++++++++
 tb/tb_instr_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_seq_pkg.sv
// rtl/instr_seq_pkg.sv - shared instruction format, opcodes and FSM encoding for instr_sequencer
package instr_seq_pkg;

    localparam int INSTR_W = 13;
    localparam int OP_MSB  = 12;
    localparam int OP_LSB  = 11;

    localparam logic [1:0] OP_STORE = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_MUL   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [1:0] instr_op(input logic [INSTR_W-1:0] instr);
        return instr[OP_MSB:OP_LSB];
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - DEPTH x W synchronous program FIFO with occupancy count
module instr_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 13
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wr_data,
    output logic [W-1:0]             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          push_ok, pop_ok;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign rd_data = mem_q[rd_ptr_q];
    assign level   = level_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - buffers a host program and issues each instruction for a per-opcode hold time
module instr_sequencer
    import instr_seq_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int HOLD_MEM = 4,
    parameter int HOLD_ADD = 4,
    parameter int HOLD_MUL = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [INSTR_W-1:0]       in_instr,
    output logic                     in_ready,
    input  logic                     start,
    output logic [INSTR_W-1:0]       instruction_Register,
    output logic                     issue_valid,
    output logic                     issue_first,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int HOLD_MAX_A = (HOLD_MEM > HOLD_ADD) ? HOLD_MEM : HOLD_ADD;
    localparam int HOLD_MAX   = (HOLD_MAX_A > HOLD_MUL) ? HOLD_MAX_A : HOLD_MUL;
    localparam int CNT_W      = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic                 valid_q, valid_d;
    logic                 first_q, first_d;
    logic                 done_q, done_d;
    logic                 pop;
    logic                 advance;
    logic                 fifo_full, fifo_empty;
    logic [INSTR_W-1:0]   head;

    // Counter is loaded with hold-1 because the ISSUE cycle itself counts as the first held cycle.
    function automatic logic [CNT_W-1:0] hold_load(input logic [1:0] op);
        case (op)
            OP_STORE: hold_load = CNT_W'(HOLD_MEM - 1);
            OP_LOAD:  hold_load = CNT_W'(HOLD_MEM - 1);
            OP_ADD:   hold_load = CNT_W'(HOLD_ADD - 1);
            OP_MUL:   hold_load = CNT_W'(HOLD_MUL - 1);
            default:  hold_load = '0;
        endcase
    endfunction

    instr_fifo #(
        .DEPTH (DEPTH),
        .W     (INSTR_W)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (in_valid),
        .pop     (pop),
        .wr_data (in_instr),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    assign in_ready             = !fifo_full;
    assign instruction_Register = instr_q;
    assign issue_valid          = valid_q;
    assign issue_first          = first_q;
    assign done                 = done_q;
    assign busy                 = (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
        valid_d = valid_q;
        first_d = 1'b0;
        done_d  = 1'b0;
        pop     = 1'b0;
        advance = 1'b0;
        case (state_q)
            ST_IDLE: advance = start;
            ST_ISSUE, ST_HOLD: begin
                if (cnt_q == '0) begin
                    advance = 1'b1;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = ST_HOLD;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Outputs are registered on the transition, so the next instruction is visible back-to-back.
        if (advance) begin
            if (!fifo_empty) begin
                pop     = 1'b1;
                instr_d = head;
                valid_d = 1'b1;
                first_d = 1'b1;
                cnt_d   = hold_load(instr_op(head));
                state_d = ST_ISSUE;
            end else begin
                valid_d = 1'b0;
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            first_q <= first_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed self-checking bench for instr_sequencer
module tb_instr_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        in_valid0 = 1'b0;
    logic [12:0] in_instr0 = '0;
    logic        start0 = 1'b0;
    logic        in_ready0, iv0, if0, busy0, done0;
    logic [12:0] ir0;
    logic [3:0]  level0;

    logic        in_valid1 = 1'b0;
    logic [12:0] in_instr1 = '0;
    logic        start1 = 1'b0;
    logic        in_ready1, iv1, if1, busy1, done1;
    logic [12:0] ir1;
    logic [3:0]  level1;

    int checks = 0;
    int errors = 0;

    logic [12:0] prog [4];
    logic [12:0] fill [9];
    logic [12:0] e_instr;
    logic        e_valid, e_first, e_done;

    always #5 clock = ~clock;

    instr_sequencer #(.DEPTH(8), .HOLD_MEM(4), .HOLD_ADD(4), .HOLD_MUL(4)) u0 (
        .clock                (clock),
        .reset                (reset),
        .in_valid             (in_valid0),
        .in_instr             (in_instr0),
        .in_ready             (in_ready0),
        .start                (start0),
        .instruction_Register (ir0),
        .issue_valid          (iv0),
        .issue_first          (if0),
        .busy                 (busy0),
        .done                 (done0),
        .level                (level0)
    );

    instr_sequencer #(.DEPTH(8), .HOLD_MEM(1), .HOLD_ADD(2), .HOLD_MUL(6)) u1 (
        .clock                (clock),
        .reset                (reset),
        .in_valid             (in_valid1),
        .in_instr             (in_instr1),
        .in_ready             (in_ready1),
        .start                (start1),
        .instruction_Register (ir1),
        .issue_valid          (iv1),
        .issue_first          (if1),
        .busy                 (busy1),
        .done                 (done1),
        .level                (level1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        prog[0] = 13'b11_00_000000000;
        prog[1] = 13'b10_00_000000000;
        prog[2] = 13'b00_00_111111100;
        prog[3] = 13'b01_10_111111100;
        for (int i = 0; i < 8; i++) fill[i] = {2'(i), 2'(i + 1), 9'(i * 37 + 5)};
        fill[8] = 13'h0A5A;

        // Reset state
        @(negedge clock);
        @(negedge clock);
        check("rst_level", level0, 0);
        check("rst_in_ready", in_ready0, 1);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_valid", iv0, 0);
        check("rst_first", if0, 0);
        check("rst_instr", ir0, 0);
        reset = 1'b0;
        tick();

        // Four-instruction program, all holds 4
        for (int i = 0; i < 4; i++) begin
            in_valid0 = 1'b1;
            in_instr0 = prog[i];
            tick();
        end
        in_valid0 = 1'b0;
        check("t1_level", level0, 4);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            e_valid = (c <= 16);
            e_first = (c <= 16) && (((c - 1) % 4) == 0);
            e_done  = (c == 17);
            e_instr = (c <= 16) ? prog[(c - 1) / 4] : prog[3];
            check($sformatf("t1_valid_c%0d", c), iv0, e_valid);
            check($sformatf("t1_first_c%0d", c), if0, e_first);
            check($sformatf("t1_done_c%0d", c), done0, e_done);
            check($sformatf("t1_instr_c%0d", c), ir0, e_instr);
            check($sformatf("t1_busy_c%0d", c), busy0, 1);
            tick();
        end
        check("t1_idle_busy", busy0, 0);
        check("t1_idle_done", done0, 0);
        check("t1_level_end", level0, 0);

        // Reset in the middle of a hold window
        in_valid0 = 1'b1;
        in_instr0 = prog[0];
        tick();
        in_instr0 = prog[2];
        tick();
        in_valid0 = 1'b0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick();
        check("mr_pre_valid", iv0, 1);
        check("mr_pre_level", level0, 1);
        reset = 1'b1;
        #1;
        check("mr_instr", ir0, 0);
        check("mr_valid", iv0, 0);
        check("mr_first", if0, 0);
        check("mr_busy", busy0, 0);
        check("mr_done", done0, 0);
        check("mr_level", level0, 0);
        check("mr_in_ready", in_ready0, 1);
        @(negedge clock);
        reset = 1'b0;
        tick();
        check("mr_after_busy", busy0, 0);
        check("mr_after_level", level0, 0);

        // Start with an empty FIFO
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("es_done", done0, 1);
        check("es_valid", iv0, 0);
        check("es_busy", busy0, 1);
        tick();
        check("es_done_clr", done0, 0);
        check("es_busy_clr", busy0, 0);
        check("es_valid_idle", iv0, 0);

        // Fill to full, drop a ninth push, then extend the program while issuing
        for (int i = 0; i < 8; i++) begin
            in_valid0 = 1'b1;
            in_instr0 = fill[i];
            tick();
        end
        check("full_level", level0, 8);
        check("full_in_ready", in_ready0, 0);
        in_instr0 = 13'h1ABC;
        tick();
        in_valid0 = 1'b0;
        check("drop_level", level0, 8);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int c = 1; c <= 38; c++) begin
            e_valid = (c <= 36);
            e_first = (c <= 36) && (((c - 1) % 4) == 0);
            e_done  = (c == 37);
            e_instr = (c <= 36) ? fill[(c - 1) / 4] : fill[8];
            check($sformatf("ext_valid_c%0d", c), iv0, e_valid);
            check($sformatf("ext_first_c%0d", c), if0, e_first);
            check($sformatf("ext_done_c%0d", c), done0, e_done);
            check($sformatf("ext_instr_c%0d", c), ir0, e_instr);
            check($sformatf("ext_busy_c%0d", c), busy0, (c <= 37));
            if (c == 1) check("ext_level_c1", level0, 7);
            if (c == 4) check("ext_ready_c4", in_ready0, 1);
            if (c == 5) check("ext_level_c5", level0, 7);
            in_valid0 = (c == 4);
            in_instr0 = fill[8];
            start0    = (c == 6);
            tick();
        end
        in_valid0 = 1'b0;
        start0 = 1'b0;
        check("ext_level_end", level0, 0);

        // Per-opcode holds: mul 6, add 2, store 1
        in_valid1 = 1'b1;
        in_instr1 = 13'b11_01_000000111;
        tick();
        in_instr1 = 13'b10_11_000011000;
        tick();
        in_instr1 = 13'b00_10_101010101;
        tick();
        in_valid1 = 1'b0;
        check("ph_level", level1, 3);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            e_valid = (c <= 9);
            e_first = (c == 1) || (c == 7) || (c == 9);
            e_done  = (c == 10);
            e_instr = (c <= 6) ? 13'b11_01_000000111 :
                      (c <= 8) ? 13'b10_11_000011000 : 13'b00_10_101010101;
            check($sformatf("ph_valid_c%0d", c), iv1, e_valid);
            check($sformatf("ph_first_c%0d", c), if1, e_first);
            check($sformatf("ph_done_c%0d", c), done1, e_done);
            check($sformatf("ph_instr_c%0d", c), ir1, e_instr);
            check($sformatf("ph_busy_c%0d", c), busy1, (c <= 10));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
